// File: rtl/csr_gpio.sv
// csr_gpio: CSR-mapped GPIO block with input synchronisers, per-bit edge
// status, interrupt enables and registered output channels.
//
// Ports
//   clk        single clock, all state on rising edge
//   rst        synchronous active-high reset
//   csr_addr   12-bit CSR address of the current access
//   csr_re     read request (sampled every cycle)
//   csr_we     write request (sampled every cycle)
//   csr_wdata  write data
//   gpio_in    asynchronous input channels, channel i at [i*WIDTH +: WIDTH]
//   csr_rdata  registered read data (holds between reads)
//   csr_rvalid one-cycle pulse when csr_rdata holds a read result
//   csr_err    one-cycle pulse on an access to an unmapped address
//   gpio_out   registered output channels, same packing as gpio_in
//   irq        registered level interrupt
module csr_gpio #(
  parameter int               WIDTH     = 32,
  parameter int               N_IN      = 2,
  parameter int               N_OUT     = 2,
  parameter logic [11:0]      IN_BASE   = 12'hf00,
  parameter logic [11:0]      OUT_BASE  = 12'hf10,
  parameter logic [11:0]      EDGE_BASE = 12'hf20,
  parameter logic [11:0]      IEN_ADDR  = 12'hf30,
  parameter logic [WIDTH-1:0] OUT_RST   = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [11:0]            csr_addr,
  input  logic                   csr_re,
  input  logic                   csr_we,
  input  logic [WIDTH-1:0]       csr_wdata,
  input  logic [N_IN*WIDTH-1:0]  gpio_in,
  output logic [WIDTH-1:0]       csr_rdata,
  output logic                   csr_rvalid,
  output logic                   csr_err,
  output logic [N_OUT*WIDTH-1:0] gpio_out,
  output logic                   irq
);

  logic [N_IN*WIDTH-1:0] sync1, sync2, prev;
  logic [WIDTH-1:0]      status [N_IN];
  logic [WIDTH-1:0]      status_nxt [N_IN];
  logic [WIDTH-1:0]      out_q [N_OUT];
  logic [N_IN-1:0]       ien;
  logic [1:0]            arm_cnt;
  logic                  armed;

  // Decode results
  logic                  hit;
  logic [WIDTH-1:0]      rd_val;
  logic [N_OUT-1:0]      out_we;
  logic [N_IN-1:0]       edge_we;
  logic                  ien_we;
  logic [N_IN-1:0]       word_pending;
  logic                  irq_nxt;

  // Counter reaches 3 only once the synchroniser and prev stages have been
  // refilled with post-reset samples, so stale levels never look like edges.
  assign armed = (arm_cnt == 2'd3);

  // Exact-compare address decode; every address not matched here is unmapped.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    hit     = 1'b0;
    rd_val  = '0;
    out_we  = '0;
    edge_we = '0;
    ien_we  = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      if (csr_addr == IN_BASE + 12'(i)) begin
        hit    = 1'b1;
        rd_val = sync2[i*WIDTH +: WIDTH];
      end
      if (csr_addr == EDGE_BASE + 12'(i)) begin
        hit        = 1'b1;
        rd_val     = status[i];
        edge_we[i] = csr_we;
      end
    end
    for (int i = 0; i < N_OUT; i++) begin
      if (csr_addr == OUT_BASE + 12'(i)) begin
        hit       = 1'b1;
        rd_val    = out_q[i];
        out_we[i] = csr_we;
      end
    end
    if (csr_addr == IEN_ADDR) begin
      hit    = 1'b1;
      rd_val = WIDTH'(ien);
      ien_we = csr_we;
    end
  end

  // Status update: clear first, then OR in new toggles so a set wins.
  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      status_nxt[i] = status[i] & ~(edge_we[i] ? csr_wdata : '0);
      if (armed)
        status_nxt[i] = status_nxt[i] |
                        (sync2[i*WIDTH +: WIDTH] ^ prev[i*WIDTH +: WIDTH]);
      word_pending[i] = (status[i] != '0);
    end
    irq_nxt = |(ien & word_pending);
  end

  always_comb begin
    for (int i = 0; i < N_OUT; i++)
      gpio_out[i*WIDTH +: WIDTH] = out_q[i];
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of statement order within the block.
    if (rst) begin
      sync1      <= '0;
      sync2      <= '0;
      prev       <= '0;
      ien        <= '0;
      arm_cnt    <= 2'd0;
      csr_rdata  <= '0;
      csr_rvalid <= 1'b0;
      csr_err    <= 1'b0;
      irq        <= 1'b0;
      // NOTE: status and out_q are small flop banks, not RAM, so they are
      // reset element by element; a real memory array would not be.
      for (int i = 0; i < N_IN; i++)  status[i] <= '0;
      for (int i = 0; i < N_OUT; i++) out_q[i]  <= OUT_RST;
    end else begin
      sync1 <= gpio_in;
      sync2 <= sync1;
      prev  <= sync2;
      if (!armed) arm_cnt <= arm_cnt + 2'd1;

      csr_rvalid <= csr_re;
      csr_err    <= (csr_re | csr_we) & ~hit;
      if (csr_re) csr_rdata <= hit ? rd_val : '0;

      for (int i = 0; i < N_IN; i++)  status[i] <= status_nxt[i];
      for (int i = 0; i < N_OUT; i++) if (out_we[i]) out_q[i] <= csr_wdata;
      if (ien_we) ien <= csr_wdata[N_IN-1:0];

      irq <= irq_nxt;
    end
  end

endmodule

// File: tb/tb_csr_gpio.sv
// Self-checking bench for csr_gpio: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model that tracks input history and register contents.
module tb_csr_gpio;

  localparam int          W      = 32;
  localparam int          N_IN   = 2;
  localparam int          N_OUT  = 2;
  localparam int          IN_B   = 'hf00;
  localparam int          OUT_B  = 'hf10;
  localparam int          EDGE_B = 'hf20;
  localparam int          IEN_A  = 'hf30;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [11:0]            csr_addr = '0;
  logic                   csr_re = 1'b0;
  logic                   csr_we = 1'b0;
  logic [W-1:0]           csr_wdata = '0;
  logic [N_IN*W-1:0]      gpio_in = '0;
  logic [W-1:0]           csr_rdata;
  logic                   csr_rvalid;
  logic                   csr_err;
  logic [N_OUT*W-1:0]     gpio_out;
  logic                   irq;

  csr_gpio dut (
    .clk(clk), .rst(rst), .csr_addr(csr_addr), .csr_re(csr_re),
    .csr_we(csr_we), .csr_wdata(csr_wdata), .gpio_in(gpio_in),
    .csr_rdata(csr_rdata), .csr_rvalid(csr_rvalid), .csr_err(csr_err),
    .gpio_out(gpio_out), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model. in_hist[k] = gpio_in value captured k+1 edges ago
  // (since reset); reads see the value from 2 edges ago, edges compare the
  // values from 2 and 3 edges ago.
  bit            m_valid = 0;
  logic [63:0]   in_hist [3];
  logic [W-1:0]  m_out [N_OUT];
  logic [W-1:0]  m_status [N_IN];
  logic [N_IN-1:0] m_ien;
  int            m_since_rst;
  logic [W-1:0]  m_rdata;
  logic          m_rvalid, m_err, m_irq;

  task automatic model_step();
    bit           mapped;
    logic [W-1:0] rv;
    logic         pend;
    int           a;
    if (rst) begin
      m_valid = 1;
      for (int k = 0; k < 3; k++) in_hist[k] = '0;
      for (int k = 0; k < N_OUT; k++) m_out[k] = '0;
      for (int k = 0; k < N_IN; k++) m_status[k] = '0;
      m_ien = '0; m_since_rst = 0;
      m_rdata = '0; m_rvalid = 0; m_err = 0; m_irq = 0;
      return;
    end
    if (!m_valid) return;
    a = int'(csr_addr);
    pend = 0;
    for (int k = 0; k < N_IN; k++) if (m_ien[k] && m_status[k] != 0) pend = 1;
    mapped = 1; rv = '0;
    if (a >= IN_B && a < IN_B + N_IN)          rv = in_hist[1][(a-IN_B)*W +: W];
    else if (a >= OUT_B && a < OUT_B + N_OUT)  rv = m_out[a-OUT_B];
    else if (a >= EDGE_B && a < EDGE_B + N_IN) rv = m_status[a-EDGE_B];
    else if (a == IEN_A)                       rv = W'(m_ien);
    else mapped = 0;
    if (csr_re) m_rdata = mapped ? rv : '0;
    m_rvalid = csr_re;
    m_err    = (csr_re || csr_we) && !mapped;
    if (csr_we && mapped) begin
      if (a >= OUT_B && a < OUT_B + N_OUT)       m_out[a-OUT_B] = csr_wdata;
      else if (a >= EDGE_B && a < EDGE_B + N_IN) m_status[a-EDGE_B] &= ~csr_wdata;
      else if (a == IEN_A)                       m_ien = csr_wdata[N_IN-1:0];
    end
    if (m_since_rst >= 3)
      for (int k = 0; k < N_IN; k++)
        m_status[k] |= in_hist[1][k*W +: W] ^ in_hist[2][k*W +: W];
    in_hist[2] = in_hist[1];
    in_hist[1] = in_hist[0];
    in_hist[0] = gpio_in;
    if (m_since_rst < 3) m_since_rst++;
    m_irq = pend;
  endtask

  task automatic compare_all();
    if (!m_valid) return;
    check("rvalid", 64'(csr_rvalid), 64'(m_rvalid));
    check("rdata", 64'(csr_rdata), 64'(m_rdata));
    check("err", 64'(csr_err), 64'(m_err));
    check("irq", 64'(irq), 64'(m_irq));
    check("gpio_out", gpio_out, {m_out[1], m_out[0]});
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic access(input bit re, input bit we, input logic [11:0] a,
                        input logic [W-1:0] d);
    csr_re = re; csr_we = we; csr_addr = a; csr_wdata = d;
    step();
    csr_re = 0; csr_we = 0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) access(0, 0, 12'h000, '0);
  endtask

  initial begin
    bit seen;
    // Reset with channel 0 held at 5 throughout.
    gpio_in = {32'h0, 32'h5};
    rst = 1;
    idle(3);
    check("rst_gpio_out", gpio_out, 64'h0);
    check("rst_irq", 64'(irq), 64'h0);
    check("rst_rvalid", 64'(csr_rvalid), 64'h0);
    rst = 0;

    access(0, 1, 12'hf11, 32'hdead_beef);
    check("wr_f11", 64'(gpio_out[63:32]), 64'hdead_beef);
    access(1, 0, 12'hf11, '0);
    check("rd_f11", 64'(csr_rdata), 64'hdead_beef);
    check("rd_f11_valid", 64'(csr_rvalid), 64'h1);

    idle(2);
    access(1, 0, 12'hf00, '0);
    check("rd_in0", 64'(csr_rdata), 64'h5);
    access(1, 0, 12'hf20, '0);
    check("rd_status0_reset", 64'(csr_rdata), 64'h0);

    // Toggle ch1 bit 3 with only channel 1 enabled.
    access(0, 1, 12'hf30, 32'h2);
    gpio_in[W+3] = 1'b1;
    seen = 0;
    for (int k = 0; k < 6 && !seen; k++) begin
      idle(1);
      seen = irq;
    end
    check("irq_rise", 64'(seen), 64'h1);
    access(1, 0, 12'hf21, '0);
    check("rd_status1", 64'(csr_rdata), 64'h8);
    access(0, 1, 12'hf21, 32'h8);
    idle(1);
    check("irq_drop", 64'(irq), 64'h0);
    access(1, 0, 12'hf21, '0);
    check("status1_clr", 64'(csr_rdata), 64'h0);

    // Clear status0 bit 0 on the exact edge a new bit-0 toggle sets it.
    gpio_in[0] = 1'b0;
    idle(2);
    access(0, 1, 12'hf20, 32'h1);
    access(1, 0, 12'hf20, '0);
    check("set_wins", 64'(csr_rdata), 64'h1);
    access(0, 1, 12'hf20, 32'h1);

    // Unmapped accesses.
    access(1, 0, 12'hf02, '0);
    check("unmap_rd_data", 64'(csr_rdata), 64'h0);
    check("unmap_rd_valid", 64'(csr_rvalid), 64'h1);
    check("unmap_rd_err", 64'(csr_err), 64'h1);
    idle(1);
    check("err_pulse", 64'(csr_err), 64'h0);
    access(0, 1, 12'hf40, 32'hffff_ffff);
    check("unmap_wr_err", 64'(csr_err), 64'h1);
    check("unmap_wr_out", gpio_out, 64'hdead_beef_0000_0000);

    // Simultaneous read and write of the same register.
    access(0, 1, 12'hf10, 32'h1);
    access(1, 1, 12'hf10, 32'h2);
    check("rw_old", 64'(csr_rdata), 64'h1);
    check("rw_new", 64'(gpio_out[31:0]), 64'h2);

    // Randomized traffic, with occasional resets and input toggles.
    for (int n = 0; n < 3000; n++) begin
      logic [11:0] a;
      case ($urandom_range(6))
        0: a = 12'(IN_B + $urandom_range(2));
        1: a = 12'(OUT_B + $urandom_range(2));
        2, 3: a = 12'(EDGE_B + $urandom_range(2));
        4: a = 12'(IEN_A + $urandom_range(1));
        default: a = 12'($urandom);
      endcase
      rst = ($urandom_range(249) == 0);
      if ($urandom_range(3) == 0) gpio_in[$urandom_range(63)] ^= 1'b1;
      access($urandom_range(1) == 1, $urandom_range(4) < 2, a,
             ($urandom_range(1) == 1) ? $urandom : (32'h1 << $urandom_range(31)));
    end
    rst = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
